video_fetcher: RTL and testbench

- Consumer end of the video address/next handshake: takes the 21-bit word address from the video address generator and issues DRAM read cycles through the arbiter.
- Pulses video_next each time an address is accepted by DRAM, which lets the generator advance.
- Buffers returned 16-bit words in a small in-order FIFO that the pixel renderer drains.
- Sits between the video address generator, the DRAM arbiter and the video renderer.

---
 rtl/video_fetcher.sv | 200 ++++++++++++++++++++
 tb/tb_video_fetcher.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetcher.sv
// Video fetch path: turns generator word addresses into DRAM reads and buffers the returned words for the renderer.
// Latency: dram_req rises 1 cycle after issue is allowed, video_next 1 cycle after ack, data visible 1 cycle after rvalid.
// Backpressure: credit-limited; no new read is issued unless FIFO words plus in-flight reads leave a free slot.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   video_addr / video_next    address from the generator / one-cycle "address consumed" pulse
//   fetch_en, flush            fetch window gate / discard buffered and pending data
//   dram_req/addr/ack          read request to the arbiter, held until acknowledged
//   dram_rvalid/rdata          in-order read returns
//   pix_data/valid/rd          FIFO head to the renderer and its pop strobe
//   ovf                        sticky: a return arrived with no space left

// Generic synchronous FIFO with a clear, head word presented combinationally from registered storage.
// Latency: a pushed word is visible at the head 1 cycle later.
// Backpressure: pushes while full are dropped (caller watches full); pops while empty are ignored.
module fifo #(
   parameter int AW = 3,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          push,
   input  logic [DW-1:0] push_dat,
   input  logic          pop,
   output logic [DW-1:0] head_dat,
   output logic          head_vld,
   output logic [AW:0]   count,
   output logic          full
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign head_vld = (count != '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_push  = push & ~full;
   assign do_pop   = pop & head_vld;
   // Gate the head so the output reads zero when empty (including out of reset).
   assign head_dat = head_vld ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers are AW bits wide, so they wrap modulo the depth on their own.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: it is only ever read through the head_vld gate.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= push_dat;
   end
endmodule

module video_fetcher #(
   parameter int AW = 3,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [20:0]   video_addr,
   output logic          video_next,
   input  logic          fetch_en,
   input  logic          flush,
   output logic          dram_req,
   output logic [20:0]   dram_addr,
   input  logic          dram_ack,
   input  logic          dram_rvalid,
   input  logic [DW-1:0] dram_rdata,
   output logic [DW-1:0] pix_data,
   output logic          pix_valid,
   input  logic          pix_rd,
   output logic          ovf
);
   localparam int          DEPTH = 1 << AW;
   localparam logic [AW:0] ONE   = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, REQ, SETTLE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW:0]   outstanding;
   logic [AW:0]   discard;
   logic [AW:0]   fifo_count;
   logic [AW+1:0] credit_sum;
   logic          credit;
   logic          issue;
   logic          acked;
   logic          rv_counted;
   logic          push;
   logic          fifo_full;

   // Words already buffered plus reads still in flight must leave room for one more.
   assign credit_sum = {1'b0, fifo_count} + {1'b0, outstanding};
   assign credit     = (credit_sum < (AW+2)'(DEPTH));
   assign issue      = (state == IDLE) & fetch_en & credit & ~flush;
   assign acked      = (state == REQ) & dram_ack;
   // A return with nothing recorded in flight is not allowed to underflow the counter.
   assign rv_counted = dram_rvalid & (outstanding != '0);
   // Returns belonging to flushed requests are swallowed; the flush cycle itself never pushes.
   assign push       = dram_rvalid & ~flush & (discard == '0);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue) state_nxt = REQ;
         // fetch_en is deliberately ignored here: an issued request always completes.
         REQ:     if (dram_ack) state_nxt = SETTLE;
         // One spare cycle lets the generator's registered address catch up after video_next.
         SETTLE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      dram_req   = 1'b0;
      video_next = 1'b0;
      case (state)
         REQ:     dram_req   = 1'b1;
         // SETTLE is entered only on ack and lasts exactly one cycle.
         SETTLE:  video_next = 1'b1;
         default: ;
      endcase
   end

   // Address is captured on issue and held for the whole REQ phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     dram_addr <= '0;
      else if (issue) dram_addr <= video_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else begin
         case ({acked, rv_counted})
            2'b10:   outstanding <= outstanding + ONE;
            2'b01:   outstanding <= outstanding - ONE;
            default: ;
         endcase
      end
   end

   // On flush every in-flight read becomes junk, except one returning in this very cycle,
   // which is dropped directly. A request acked during the flush is not counted here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         discard <= '0;
      end else if (flush) begin
         discard <= rv_counted ? (outstanding - ONE) : outstanding;
      end else if (dram_rvalid && (discard != '0)) begin
         discard <= discard - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                ovf <= 1'b0;
      else if (push & fifo_full) ovf <= 1'b1;
   end

   fifo #(
      .AW (AW),
      .DW (DW)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (flush),
      .push     (push),
      .push_dat (dram_rdata),
      .pop      (pix_rd),
      .head_dat (pix_data),
      .head_vld (pix_valid),
      .count    (fifo_count),
      .full     (fifo_full)
   );
endmodule

// File: tb/tb_video_fetcher.sv
// Directed bench for video_fetcher: reset, basic fetch, ack stall, credit limit,
// simultaneous push/pop, flush discard accounting and asynchronous reset mid-request.
module tb_video_fetcher;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [20:0] video_addr = '0;
   logic        video_next;
   logic        fetch_en = 1'b0;
   logic        flush = 1'b0;
   logic        dram_req;
   logic [20:0] dram_addr;
   logic        dram_ack = 1'b0;
   logic        dram_rvalid = 1'b0;
   logic [15:0] dram_rdata = '0;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_rd = 1'b0;
   logic        ovf;

   int checks = 0;
   int failures = 0;

   // Responder state for the auto-acking memory model.
   logic [20:0] exp_addr;
   int          data_idx;
   int          reqs;
   int          nexts;
   logic        d1v, d2v;
   logic [15:0] d1d, d2d;

   video_fetcher #(.AW(3), .DW(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .video_addr  (video_addr),
      .video_next  (video_next),
      .fetch_en    (fetch_en),
      .flush       (flush),
      .dram_req    (dram_req),
      .dram_addr   (dram_addr),
      .dram_ack    (dram_ack),
      .dram_rvalid (dram_rvalid),
      .dram_rdata  (dram_rdata),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_rd      (pix_rd),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Auto-acking memory: every request is acked in its first cycle, data returns two cycles later.
   // The generator advances video_addr on each video_next; fetch_en drops once maxreq requests are seen.
   task automatic run(input int ncyc, input int maxreq);
      d1v = 1'b0; d2v = 1'b0; d1d = '0; d2d = '0;
      dram_ack = 1'b1;
      fetch_en = (reqs < maxreq);
      tick();
      for (int i = 0; i < ncyc; i++) begin
         dram_rvalid = d2v;
         dram_rdata  = d2d;
         d2v = d1v;
         d2d = d1d;
         d1v = 1'b0;
         if (dram_req) begin
            check("run_addr", 32'(dram_addr), 32'(exp_addr));
            exp_addr = exp_addr + 21'd1;
            d1v = 1'b1;
            d1d = 16'h0100 + 16'(data_idx);
            data_idx++;
            reqs++;
         end
         if (video_next) begin
            nexts++;
            video_addr = video_addr + 21'd1;
         end
         fetch_en = (reqs < maxreq);
         tick();
      end
      dram_rvalid = 1'b0;
      dram_ack = 1'b0;
   endtask

   // One request acked in its first cycle; leaves the FSM back in IDLE.
   task automatic issue_one(input logic [20:0] a, input string tag);
      video_addr = a;
      fetch_en = 1'b1;
      tick();
      check({tag, "_req"}, 32'(dram_req), 32'd1);
      check({tag, "_addr"}, 32'(dram_addr), 32'(a));
      dram_ack = 1'b1;
      fetch_en = 1'b0;
      tick();
      check({tag, "_next"}, 32'(video_next), 32'd1);
      dram_ack = 1'b0;
      tick();
   endtask

   task automatic ret(input logic [15:0] d);
      dram_rvalid = 1'b1;
      dram_rdata = d;
      tick();
      dram_rvalid = 1'b0;
   endtask

   task automatic pop();
      pix_rd = 1'b1;
      tick();
      pix_rd = 1'b0;
   endtask

   initial begin
      // ---------------- reset ----------------
      #2 rst_n = 1'b0;
      tick();
      tick();
      check("rst_req", 32'(dram_req), 32'd0);
      check("rst_addr", 32'(dram_addr), 32'd0);
      check("rst_next", 32'(video_next), 32'd0);
      check("rst_pvalid", 32'(pix_valid), 32'd0);
      check("rst_pdata", 32'(pix_data), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      tick();

      // ---------------- basic ----------------
      video_addr = 21'h0A000;
      fetch_en = 1'b1;
      tick();
      check("basic_req", 32'(dram_req), 32'd1);
      check("basic_addr", 32'(dram_addr), 32'h0A000);
      check("basic_next_early", 32'(video_next), 32'd0);
      dram_ack = 1'b1;
      fetch_en = 1'b0;
      tick();
      check("basic_next", 32'(video_next), 32'd1);
      check("basic_req_drop", 32'(dram_req), 32'd0);
      dram_ack = 1'b0;
      tick();
      check("basic_next_once", 32'(video_next), 32'd0);
      ret(16'h1234);
      check("basic_pvalid", 32'(pix_valid), 32'd1);
      check("basic_pdata", 32'(pix_data), 32'h1234);
      pop();
      check("basic_empty", 32'(pix_valid), 32'd0);

      // ---------------- ack stall ----------------
      video_addr = 21'h1ABCD;
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("stall_req", 32'(dram_req), 32'd1);
         check("stall_addr", 32'(dram_addr), 32'h1ABCD);
         check("stall_next", 32'(video_next), 32'd0);
         if (i == 5) dram_ack = 1'b1;
         tick();
      end
      check("stall_next_ack", 32'(video_next), 32'd1);
      check("stall_req_drop", 32'(dram_req), 32'd0);
      dram_ack = 1'b0;
      tick();
      check("stall_next_once", 32'(video_next), 32'd0);
      ret(16'hBEEF);
      check("stall_pdata", 32'(pix_data), 32'hBEEF);
      pop();

      // ---------------- credit / full ----------------
      video_addr = 21'h00100;
      exp_addr = 21'h00100;
      data_idx = 0; reqs = 0; nexts = 0;
      run(40, 100);
      check("full_reqs", 32'(reqs), 32'd8);
      check("full_nexts", 32'(nexts), 32'd8);
      check("full_ovf", 32'(ovf), 32'd0);
      check("full_pvalid", 32'(pix_valid), 32'd1);
      check("full_head", 32'(pix_data), 32'h0100);
      pop();
      reqs = 0;
      run(20, 100);
      fetch_en = 1'b0;
      check("full_refill_reqs", 32'(reqs), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         check("full_order", 32'(pix_data), 32'h0100 + 32'(i));
         pop();
      end
      check("full_drained", 32'(pix_valid), 32'd0);
      check("full_ovf_end", 32'(ovf), 32'd0);

      // ---------------- simultaneous push/pop ----------------
      exp_addr = video_addr;
      data_idx = 32'h20; reqs = 0;
      run(20, 4);
      check("sim_reqs", 32'(reqs), 32'd4);
      issue_one(21'h0F00F, "sim");
      check("sim_head", 32'(pix_data), 32'h0120);
      dram_rvalid = 1'b1;
      dram_rdata = 16'h5A5A;
      pix_rd = 1'b1;
      tick();
      dram_rvalid = 1'b0;
      pix_rd = 1'b0;
      check("sim_head2", 32'(pix_data), 32'h0121);
      check("sim_d1", 32'(pix_data), 32'h0121); pop();
      check("sim_d2", 32'(pix_data), 32'h0122); pop();
      check("sim_d3", 32'(pix_data), 32'h0123); pop();
      check("sim_d4", 32'(pix_data), 32'h5A5A); pop();
      check("sim_empty", 32'(pix_valid), 32'd0);

      // ---------------- flush with 2 outstanding ----------------
      issue_one(21'h00200, "fl0");
      ret(16'h1111);
      check("fl_pre", 32'(pix_valid), 32'd1);
      issue_one(21'h00201, "fl1");
      issue_one(21'h00202, "fl2");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_emptied", 32'(pix_valid), 32'd0);
      ret(16'hDEAD);
      ret(16'hBEEF);
      check("fl_discarded", 32'(pix_valid), 32'd0);
      issue_one(21'h00203, "fl3");
      ret(16'h7777);
      check("fl_kept_valid", 32'(pix_valid), 32'd1);
      check("fl_kept_data", 32'(pix_data), 32'h7777);
      pop();

      // flush with a return in the same cycle: that return counts against the discard
      issue_one(21'h00300, "fr0");
      issue_one(21'h00301, "fr1");
      flush = 1'b1;
      dram_rvalid = 1'b1;
      dram_rdata = 16'hAAAA;
      tick();
      flush = 1'b0;
      dram_rdata = 16'hBBBB;
      tick();
      dram_rvalid = 1'b0;
      check("fr_discarded", 32'(pix_valid), 32'd0);
      issue_one(21'h00302, "fr2");
      ret(16'hCCCC);
      check("fr_kept_valid", 32'(pix_valid), 32'd1);
      check("fr_kept_data", 32'(pix_data), 32'hCCCC);
      pop();

      // flush in IDLE blocks issue for that cycle only
      video_addr = 21'h00400;
      fetch_en = 1'b1;
      flush = 1'b1;
      tick();
      check("fb_blocked", 32'(dram_req), 32'd0);
      flush = 1'b0;
      tick();
      check("fb_issue", 32'(dram_req), 32'd1);
      dram_ack = 1'b1;
      fetch_en = 1'b0;
      tick();
      dram_ack = 1'b0;
      tick();
      ret(16'h4444);
      check("fb_data", 32'(pix_data), 32'h4444);

      // ---------------- reset mid-REQ ----------------
      video_addr = 21'h1F0F0;
      fetch_en = 1'b1;
      tick();
      check("mr_req", 32'(dram_req), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mr_req_async", 32'(dram_req), 32'd0);
      check("mr_pvalid_async", 32'(pix_valid), 32'd0);
      check("mr_pdata_async", 32'(pix_data), 32'd0);
      fetch_en = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("mr_idle", 32'(dram_req), 32'd0);
      video_addr = 21'h12345;
      fetch_en = 1'b1;
      tick();
      check("mr_reissue", 32'(dram_req), 32'd1);
      check("mr_addr", 32'(dram_addr), 32'h12345);
      dram_ack = 1'b1;
      fetch_en = 1'b0;
      tick();
      check("mr_next", 32'(video_next), 32'd1);
      dram_ack = 1'b0;
      tick();
      check("end_ovf", 32'(ovf), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
